// File: rtl/uart_rx_fifo_if.sv
// Receive-side FIFO head interface for uart_rx_fifo.
// master: the receiver drives the head word (dataOut, parityErr, framingErr),
//         valid and the occupancy level, and samples the consumer's ready.
// slave : the consumer samples the head word and drives ready to pop.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       dataOut;
  logic             parityErr;
  logic             framingErr;
  logic             valid;
  logic             ready;
  logic [LVL_W-1:0] level;

  modport master (
    output dataOut, parityErr, framingErr, valid, level,
    input  ready
  );

  modport slave (
    input  dataOut, parityErr, framingErr, valid, level,
    output ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with a show-ahead receive FIFO, break and line-silence detection.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx                asynchronous serial input (idles high)
//   dataBits          data bits per character: 0..3 -> 5..8
//   hasParity         parity bit present
//   parityMode        0=even 1=odd 2=mark 3=space
//   extraStopBit      1 = two stop bits
//   clockDivisor      clocks per bit (>= 4)
//   silenceBits       idle bit-times before silence asserts, 0 disables
//   fifoIf            FIFO head: dataOut/parityErr/framingErr/valid/level out, ready in
//   overflow          sticky dropped-character flag, cleared by overflowClr
//   breakPulse        one-cycle pulse when a break is detected
//   silence           line has been idle for silenceBits bit-times
module uart_rx_fifo #(
  parameter int DIV_W = 24,
  parameter int DEPTH = 8,
  parameter int SIL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [1:0]       dataBits,
  input  logic             hasParity,
  input  logic [1:0]       parityMode,
  input  logic             extraStopBit,
  input  logic [DIV_W-1:0] clockDivisor,
  input  logic [SIL_W-1:0] silenceBits,
  uart_rx_fifo_if.master   fifoIf,
  output logic             overflow,
  input  logic             overflowClr,
  output logic             breakPulse,
  output logic             silence
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} stateT;

  stateT            state, stateNext;
  logic             rxMeta, rxs, rxPrev;
  logic [DIV_W-1:0] bitCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       dataReg;
  logic             parBit, parErr, frmErr, stopIdx;
  logic             tick, lastData, parExp, brkCond;
  logic             doPush, doBreak;
  logic             pushReq;
  logic [9:0]       pushWord;

  // ---------------- synchronizer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxs    <= rxMeta;
      rxPrev <= rxs;
    end
  end

  assign tick     = (bitCnt == '0);
  assign lastData = (bitIdx == (3'd4 + {1'b0, dataBits}));
  // Unused upper data bits are held at zero, so a full-width XOR is correct.
  always_comb begin
    parExp = 1'b0;
    case (parityMode)
      2'd0:    parExp = ^dataReg;
      2'd1:    parExp = ~^dataReg;
      2'd2:    parExp = 1'b1;
      default: parExp = 1'b0;
    endcase
  end
  assign brkCond = !rxs && (dataReg == '0) && !(hasParity && parBit);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doPush    = 1'b0;
    doBreak   = 1'b0;
    case (state)
      IDLE:    if (rxPrev && !rxs) stateNext = START;
      START:   if (tick) stateNext = rxs ? IDLE : DATA;
      DATA:    if (tick && lastData) stateNext = hasParity ? PARITY : STOP;
      PARITY:  if (tick) stateNext = STOP;
      STOP: begin
        if (tick) begin
          if (!stopIdx && brkCond) begin
            doBreak   = 1'b1;
            stateNext = BRKWAIT;
          end else if (stopIdx || !extraStopBit) begin
            doPush    = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      BRKWAIT: if (rxs) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------- receive datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitCnt     <= '0;
      bitIdx     <= '0;
      dataReg    <= '0;
      parBit     <= 1'b0;
      parErr     <= 1'b0;
      frmErr     <= 1'b0;
      stopIdx    <= 1'b0;
      pushReq    <= 1'b0;
      pushWord   <= '0;
      breakPulse <= 1'b0;
    end else begin
      pushReq    <= doPush;
      breakPulse <= doBreak;
      // The last stop sample is folded into the framing flag as it is pushed.
      if (doPush) pushWord <= {frmErr | ~rxs, parErr, dataReg};

      if (state == IDLE) begin
        bitIdx  <= '0;
        dataReg <= '0;
        parBit  <= 1'b0;
        parErr  <= 1'b0;
        frmErr  <= 1'b0;
        stopIdx <= 1'b0;
        if (rxPrev && !rxs) bitCnt <= clockDivisor >> 1;
      end else if (state != BRKWAIT) begin
        bitCnt <= tick ? clockDivisor - DIV_W'(1) : bitCnt - DIV_W'(1);
        if (tick) begin
          case (state)
            DATA: begin
              dataReg[bitIdx] <= rxs;
              bitIdx          <= bitIdx + 3'd1;
            end
            PARITY: begin
              parBit <= rxs;
              parErr <= (rxs != parExp);
            end
            STOP: begin
              stopIdx <= 1'b1;
              if (!rxs) frmErr <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- silence detection ----------------
  logic [DIV_W-1:0] bitTimer;
  logic [SIL_W-1:0] silCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitTimer <= '0;
      silCnt   <= '0;
    end else if (state != IDLE || !rxs || silenceBits == '0) begin
      bitTimer <= '0;
      silCnt   <= '0;
    end else if (bitTimer >= clockDivisor - DIV_W'(1)) begin
      bitTimer <= '0;
      if (silCnt < silenceBits) silCnt <= silCnt + SIL_W'(1);
    end else begin
      bitTimer <= bitTimer + DIV_W'(1);
    end
  end

  assign silence = (silenceBits != '0) && (silCnt >= silenceBits);

  // ---------------- FIFO ----------------
  logic [9:0]       mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [LVL_W-1:0] count;
  logic             validInt, full, pop, wrEn;
  logic [9:0]       headWord;

  assign validInt = (count != '0);
  assign full     = (count == LVL_W'(DEPTH));
  assign pop      = validInt && fifoIf.ready;
  // When full, a simultaneous pop frees the slot being written.
  assign wrEn     = pushReq && (!full || pop);

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= pushWord;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + LVL_W'(wrEn) - LVL_W'(pop);
      if (pushReq && full && !pop) overflow <= 1'b1;
      else if (overflowClr)        overflow <= 1'b0;
    end
  end

  assign headWord          = mem[rdPtr];
  assign fifoIf.valid      = validInt;
  assign fifoIf.level      = count;
  assign fifoIf.dataOut    = validInt ? headWord[7:0] : '0;
  assign fifoIf.parityErr  = validInt & headWord[8];
  assign fifoIf.framingErr = validInt & headWord[9];
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [1:0]  dataBits = 2'd3;
  logic        hasParity = 1'b0;
  logic [1:0]  parityMode = 2'd0;
  logic        extraStopBit = 1'b0;
  logic [23:0] clockDivisor = 24'd10;
  logic [7:0]  silenceBits = 8'd0;
  logic        overflow, overflowClr = 1'b0, breakPulse, silence;

  int nTests = 0;
  int nFail  = 0;
  int brkCount = 0;

  uart_rx_fifo_if #(.DEPTH(4)) fifoIf ();

  uart_rx_fifo #(.DIV_W(24), .DEPTH(4), .SIL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .dataBits(dataBits), .hasParity(hasParity),
    .parityMode(parityMode), .extraStopBit(extraStopBit), .clockDivisor(clockDivisor),
    .silenceBits(silenceBits), .fifoIf(fifoIf), .overflow(overflow),
    .overflowClr(overflowClr), .breakPulse(breakPulse), .silence(silence)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (breakPulse === 1'b1) brkCount <= brkCount + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic v);
    rx = v;
    clks(DIV);
  endtask

  task automatic sendChar(input logic [7:0] d, input int nData, input bit usePar,
                          input logic parBit, input int nStop, input logic lastStop);
    sendBit(1'b0);
    for (int i = 0; i < nData; i++) sendBit(d[i]);
    if (usePar) sendBit(parBit);
    for (int i = 0; i < nStop; i++) sendBit((i == nStop - 1) ? lastStop : 1'b1);
    rx = 1'b1;
  endtask

  task automatic popOne();
    fifoIf.ready = 1'b1;
    clks(1);
    fifoIf.ready = 1'b0;
  endtask

  task automatic checkHead(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    chk({tag, ".valid"}, fifoIf.valid, 1'b1);
    chk({tag, ".data"},  fifoIf.dataOut, d);
    chk({tag, ".par"},   fifoIf.parityErr, pe);
    chk({tag, ".frm"},   fifoIf.framingErr, fe);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int brk0, n;
    fifoIf.ready = 1'b0;
    clks(3);
    chk("rst.valid", fifoIf.valid, 0);
    chk("rst.level", fifoIf.level, 0);
    chk("rst.data",  fifoIf.dataOut, 0);
    chk("rst.ovf",   overflow, 0);
    chk("rst.brk",   breakPulse, 0);
    chk("rst.sil",   silence, 0);
    rst_n = 1'b1;
    clks(5);

    // 8N1 0xA5
    sendChar(8'hA5, 8, 0, 0, 1, 1);
    clks(3);
    checkHead("a5", 8'hA5, 0, 0);
    chk("a5.level", fifoIf.level, 1);
    popOne();
    chk("a5.popLevel", fifoIf.level, 0);

    // 8E1 0x03 with wrong parity bit 1
    hasParity = 1'b1; parityMode = 2'd0;
    sendChar(8'h03, 8, 1, 1, 1, 1);
    clks(3);
    checkHead("even", 8'h03, 1, 0);
    popOne();

    // 7O1 0x41, parity bit 1 is correct
    dataBits = 2'd2; parityMode = 2'd1;
    sendChar(8'h41, 7, 1, 1, 1, 1);
    clks(3);
    checkHead("odd7", 8'h41, 0, 0);
    popOne();

    // 8M1 0x80, parity bit 0 is wrong for mark
    dataBits = 2'd3; parityMode = 2'd2;
    sendChar(8'h80, 8, 1, 0, 1, 1);
    clks(3);
    checkHead("mark", 8'h80, 1, 0);
    popOne();

    // 5N2 0x1F, second stop bit low -> framing error
    dataBits = 2'd0; hasParity = 1'b0; extraStopBit = 1'b1;
    sendChar(8'h1F, 5, 0, 0, 2, 0);
    clks(3);
    checkHead("frm5", 8'h1F, 0, 1);
    popOne();

    // 8N1 0x00 with good stop: a normal character, not a break
    dataBits = 2'd3; extraStopBit = 1'b0;
    brk0 = brkCount;
    sendChar(8'h00, 8, 0, 0, 1, 1);
    clks(3);
    checkHead("zero", 8'h00, 0, 0);
    chk("zero.noBrk", brkCount - brk0, 0);
    popOne();

    // overflow with DEPTH=4
    sendChar(8'h11, 8, 0, 0, 1, 1);
    sendChar(8'h22, 8, 0, 0, 1, 1);
    sendChar(8'h33, 8, 0, 0, 1, 1);
    sendChar(8'h44, 8, 0, 0, 1, 1);
    chk("ovf.beforeFifth", overflow, 0);
    sendChar(8'h55, 8, 0, 0, 1, 1);
    clks(3);
    chk("ovf.level", fifoIf.level, 4);
    chk("ovf.flag",  overflow, 1);
    chk("ovf.head",  fifoIf.dataOut, 8'h11);
    overflowClr = 1'b1;
    clks(1);
    overflowClr = 1'b0;
    chk("ovf.clr", overflow, 0);
    chk("ovf.head2", fifoIf.dataOut, 8'h11);
    popOne();
    chk("ovf.d22", fifoIf.dataOut, 8'h22);
    chk("ovf.l3",  fifoIf.level, 3);
    popOne();
    chk("ovf.d33", fifoIf.dataOut, 8'h33);
    popOne();
    chk("ovf.d44", fifoIf.dataOut, 8'h44);
    popOne();
    chk("ovf.empty", fifoIf.valid, 0);
    popOne();
    chk("ovf.popEmpty", fifoIf.level, 0);

    // break: rx low for 30 bit-times
    brk0 = brkCount;
    rx = 1'b0;
    clks(30 * DIV);
    rx = 1'b1;
    clks(30);
    chk("brk.count", brkCount - brk0, 1);
    chk("brk.level", fifoIf.level, 0);
    sendChar(8'h5A, 8, 0, 0, 1, 1);
    clks(3);
    checkHead("postBrk", 8'h5A, 0, 0);
    popOne();

    // silence
    silenceBits = 8'd3;
    clks(40);
    chk("sil.idle", silence, 1);
    fork
      sendChar(8'h3C, 8, 0, 0, 1, 1);
      begin
        clks(5);
        chk("sil.clrOnStart", silence, 0);
      end
    join
    n = 0;
    while (!silence && n < 100) begin
      clks(1);
      n++;
    end
    chk("sil.delay", (n >= 27 && n <= 31), 1);
    checkHead("sil", 8'h3C, 0, 0);
    popOne();
    silenceBits = 8'd0;

    // reset in the middle of DATA
    brk0 = brkCount;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    rst_n = 1'b0;
    rx = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(150);
    chk("midRst.valid", fifoIf.valid, 0);
    chk("midRst.level", fifoIf.level, 0);
    chk("midRst.noBrk", brkCount - brk0, 0);
    sendChar(8'hC3, 8, 0, 0, 1, 1);
    clks(3);
    checkHead("postRst", 8'hC3, 0, 0);
    chk("postRst.level", fifoIf.level, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DIV_W, default 24, width of clockDivisor.
REQ-002 Parameter DEPTH, default 8, FIFO depth in words; power of two, >= 2.
REQ-003 Parameter SIL_W, default 8, width of silenceBits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rx  in  1  serial line, asynchronous, idles high.
REQ-007 dataBits  in  2  data bits per character: 0=5, 1=6, 2=7, 3=8.
REQ-008 hasParity  in  1  parity bit present.
REQ-009 parityMode  in  2  parity type: 0=even, 1=odd, 2=mark, 3=space.
REQ-010 extraStopBit  in  1  1 = two stop bits, 0 = one.
REQ-011 clockDivisor  in  DIV_W  clocks per bit, legal values >= 4.
REQ-012 silenceBits  in  SIL_W  idle bit-times before silence asserts; 0 disables.
REQ-013 dataOut  out  8  FIFO head data, LSB-aligned, unused MSBs zero.
REQ-014 parityErr  out  1  parity error flag of FIFO head.
REQ-015 framingErr  out  1  framing error flag of FIFO head.
REQ-016 valid  out  1  FIFO not empty.
REQ-017 ready  in  1  pop request; pop occurs when valid && ready.
REQ-018 level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-019 overflow  out  1  sticky: a character was dropped.
REQ-020 overflowClr  in  1  clears overflow.
REQ-021 break  out  1  one-cycle pulse on break detection.
REQ-022 silence  out  1  line idle for silenceBits bit-times.

Function
REQ-023 rx passes through a two-flop synchronizer; all logic uses the synchronized value rxs.
REQ-024 FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
REQ-025 IDLE -> START on rxs falling edge; bit counter loads floor(clockDivisor/2).
REQ-026 START samples rxs when the counter expires; rxs=1 returns to IDLE (glitch), no push; rxs=0 -> DATA.
REQ-027 Each later sample is taken clockDivisor clocks after the previous one.
REQ-028 DATA samples dataBits+5 bits, LSB first, then goes to PARITY if hasParity, else STOP.
REQ-029 Parity error when the sampled bit differs from the expected value: even = XOR of data, odd = inverted XOR, mark = 1, space = 0.
REQ-030 STOP samples 1 or 2 stop bits; any low stop sample sets framingErr for the character.
REQ-031 Break: data bits, parity bit (if present) and first stop bit all 0 -> no push, break pulses once, go to BRKWAIT.
REQ-032 BRKWAIT -> IDLE when rxs=1.
REQ-033 Otherwise {framingErr, parityErr, data} is pushed on the clock after the last stop sample; valid/dataOut reflect it on the following cycle when the FIFO was empty.
REQ-034 FIFO is show-ahead; head outputs hold until popped.
REQ-035 Push while full and no pop: word dropped, overflow set.
REQ-036 Push and pop in the same cycle while full: both succeed, level unchanged, no overflow.
REQ-037 Push and pop in the same cycle otherwise: level unchanged.
REQ-038 Pop while empty: ignored.
REQ-039 Pointers wrap modulo DEPTH.
REQ-040 overflowClr clears overflow; an overflow set in the same cycle wins.
REQ-041 The silence counter counts bit-times only while in IDLE with rxs=1.
REQ-042 silence asserts when the count reaches silenceBits; the count saturates.
REQ-043 The count and silence clear on leaving IDLE, on rxs=0, or when silenceBits=0.
REQ-044 Configuration inputs may change only while in IDLE; changes at other times give undefined results for the current frame.

Reset
REQ-045 On rst_n low: FSM=IDLE, synchronizer=1, FIFO empty, level=0, valid=0, dataOut=0, parityErr=0, framingErr=0, overflow=0, break=0, silence=0, counters=0.
REQ-046 Reset mid-frame discards the partial character; no push after release.

Verification
REQ-047 clockDivisor=10, 8N1, send 0xA5 -> one push, dataOut=0xA5, both errors 0, level=1.
REQ-048 8E1, send 0x03 with parity bit 1 -> parityErr=1, dataOut=0x03.
REQ-049 DEPTH=4, send 5 characters with ready=0 -> level=4, overflow=1, head = first character; overflowClr -> overflow=0.
REQ-050 rx low 30 bit-times at clockDivisor=10 -> exactly one break pulse, no push, IDLE after rx returns high.
REQ-051 silenceBits=3, clockDivisor=10, line idle after a frame -> silence=1 about 30 clocks after the stop sample; clears on the next start edge.
REQ-052 Assert rst_n low during DATA, then release with rx idle -> valid=0, level=0, FSM=IDLE.
